// File: rtl/twdl_pkg.sv
// Shared constants and types for the mixed-radix twiddle index generator.
// Lane count, default index width, FSM encoding and sticky error bit positions.
package twdl_pkg;

    localparam int NLANE  = 5;
    localparam int wTwIdx = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ERR_VAL_IDLE = 0;
    localparam int ERR_UDF      = 1;
    localparam int ERR_OVF      = 2;

endpackage

// File: rtl/twdl_idx_gen_cta_ff_addr_sync.sv
// Synchronous address FIFO with synchronous clear, registered read port and occupancy count.
// Full/empty are registered from the next-count so they always agree with the count.
module ff_addr_sync #(
    parameter int W     = 12,
    parameter int DEPTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_sclr,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_empty,
    output logic         o_full,
    output logic         o_ovf,
    output logic         o_udf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_cnt;

    logic          w_has_data;
    logic          w_is_full;
    logic          w_do_pop;
    logic          w_do_push;
    logic [AW:0]   w_cnt_nxt;

    assign w_has_data = (r_cnt != '0);
    assign w_is_full  = (r_cnt == CNT_FULL);
    // A pop in the same cycle frees the slot, so a full FIFO can still take the push.
    assign w_do_pop   = i_pop && w_has_data && !i_sclr;
    assign w_do_push  = i_push && !i_sclr && (!w_is_full || w_do_pop);
    assign o_ovf      = i_push && !i_sclr && !w_do_push;
    assign o_udf      = i_pop && !i_sclr && !w_has_data;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_sclr) begin
            w_cnt_nxt = '0;
        end else if (w_do_push && !w_do_pop) begin
            w_cnt_nxt = r_cnt + CNT_ONE;
        end else if (w_do_pop && !w_do_push) begin
            w_cnt_nxt = r_cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            o_dout  <= '0;
            o_empty <= 1'b1;
            o_full  <= 1'b0;
        end else begin
            if (i_sclr) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_do_push) begin
                    r_mem[r_wptr] <= i_din;
                    r_wptr        <= r_wptr + PTR_ONE;
                end
                if (w_do_pop) begin
                    o_dout <= r_mem[r_rptr];
                    r_rptr <= r_rptr + PTR_ONE;
                end
            end
            r_cnt   <= w_cnt_nxt;
            o_empty <= (w_cnt_nxt == '0);
            o_full  <= (w_cnt_nxt == CNT_FULL);
        end
    end

endmodule

// File: rtl/twdl_idx_gen_cta.sv
// Twiddle index generator for one radix stage: per-lane numerators n*k via accumulators,
// latched radix/denominator, and a FIFO of matching group addresses for the multiplier.
//
//  state | meaning
//  IDLE  | waiting for start; in_val here is flagged
//  RUN   | each in_val beat emits numerators for the current k
//  DONE  | one-cycle stage_done pulse, then back to IDLE
module twdl_idx_gen_cta
    import twdl_pkg::*;
#(
    parameter int wTwIdx   = 12,
    parameter int wAddr    = 12,
    parameter int FF_DEPTH = 32,
    parameter int wBlk     = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [2:0]                     cfg_factor,
    input  logic [wTwIdx-1:0]              cfg_demontr,
    input  logic [wTwIdx-1:0]              cfg_ngrp,
    input  logic [wBlk-1:0]                cfg_nblk,
    input  logic                           in_val,
    output logic                           out_val,
    output logic [2:0]                     factor,
    output logic [0:NLANE-1][wTwIdx-1:0]   twdl_numrtr,
    output logic [wTwIdx-1:0]              twdl_demontr,
    input  logic                           rdreq_ff_addr,
    input  logic                           sclr_ff_addr,
    output logic [wAddr-1:0]               rdaddr,
    output logic                           ff_empty,
    output logic                           ff_full,
    output logic                           stage_done,
    output logic [2:0]                     err_flags
);

    localparam logic [wTwIdx-1:0] ONE_TW   = wTwIdx'(1);
    localparam logic [wBlk-1:0]   ONE_BLK  = wBlk'(1);
    localparam logic [wAddr-1:0]  ONE_ADDR = wAddr'(1);

    state_t                          r_state;
    logic [wTwIdx-1:0]               r_ngrp;
    logic [wBlk-1:0]                 r_nblk;
    logic [wTwIdx-1:0]               r_k;
    logic [wBlk-1:0]                 r_blk;
    logic [wAddr-1:0]                r_beat;
    logic [0:NLANE-1][wTwIdx-1:0]    r_acc;

    logic                            w_last_k;
    logic                            w_last_blk;
    logic                            w_beat_ok;
    logic                            w_ff_ovf;
    logic                            w_ff_udf;

    assign w_last_k   = (r_k == r_ngrp - ONE_TW);
    assign w_last_blk = (r_blk == r_nblk - ONE_BLK);
    assign w_beat_ok  = (r_state == RUN) && in_val && !start;

    ff_addr_sync #(
        .W     (wAddr),
        .DEPTH (FF_DEPTH)
    ) u_ff_addr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_sclr  (sclr_ff_addr),
        .i_push  (w_beat_ok),
        .i_din   (r_beat),
        .i_pop   (rdreq_ff_addr),
        .o_dout  (rdaddr),
        .o_empty (ff_empty),
        .o_full  (ff_full),
        .o_ovf   (w_ff_ovf),
        .o_udf   (w_ff_udf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ngrp       <= '0;
            r_nblk       <= '0;
            r_k          <= '0;
            r_blk        <= '0;
            r_beat       <= '0;
            r_acc        <= '0;
            out_val      <= 1'b0;
            factor       <= '0;
            twdl_numrtr  <= '0;
            twdl_demontr <= '0;
            stage_done   <= 1'b0;
            err_flags    <= '0;
        end else begin
            out_val    <= 1'b0;
            stage_done <= (r_state == DONE);
            if (w_ff_ovf) err_flags[ERR_OVF] <= 1'b1;
            if (w_ff_udf) err_flags[ERR_UDF] <= 1'b1;

            // start from any state reloads the stage; the address FIFO is left alone
            if (start) begin
                r_state      <= RUN;
                factor       <= cfg_factor;
                twdl_demontr <= cfg_demontr;
                r_ngrp       <= cfg_ngrp;
                r_nblk       <= cfg_nblk;
                r_k          <= '0;
                r_blk        <= '0;
                r_beat       <= '0;
                r_acc        <= '0;
                err_flags    <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (in_val) err_flags[ERR_VAL_IDLE] <= 1'b1;
                    end
                    RUN: begin
                        if (in_val) begin
                            out_val <= 1'b1;
                            for (int n = 0; n < NLANE; n++) begin
                                twdl_numrtr[n] <= (n < int'(factor)) ? r_acc[n] : '0;
                            end
                            r_beat <= r_beat + ONE_ADDR;
                            if (w_last_k) begin
                                r_k   <= '0;
                                r_acc <= '0;
                                r_blk <= r_blk + ONE_BLK;
                                if (w_last_blk) r_state <= DONE;
                            end else begin
                                r_k <= r_k + ONE_TW;
                                for (int n = 0; n < NLANE; n++) begin
                                    r_acc[n] <= r_acc[n] + wTwIdx'(n);
                                end
                            end
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_twdl_idx_gen_cta.sv
// Self-checking bench for twdl_idx_gen_cta: stage table plus FIFO, idle and reset sequences.
// Numerator outputs are scoreboarded; FIFO, flags and stage_done are checked every cycle.
module tb_twdl_idx_gen_cta;

    localparam int W  = 12;
    localparam int AW = 12;
    localparam int D  = 32;
    localparam int WB = 8;

    typedef logic [0:4][W-1:0] num_t;
    typedef struct {
        int   r;
        int   n;
        int   m;
        int   nblk;
        int   gap;
        num_t last;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [2:0]      cfg_factor = '0;
    logic [W-1:0]    cfg_demontr = '0;
    logic [W-1:0]    cfg_ngrp = '0;
    logic [WB-1:0]   cfg_nblk = '0;
    logic            in_val = 1'b0;
    logic            rdreq_ff_addr = 1'b0;
    logic            sclr_ff_addr = 1'b0;
    logic            out_val;
    logic [2:0]      factor;
    num_t            twdl_numrtr;
    logic [W-1:0]    twdl_demontr;
    logic [AW-1:0]   rdaddr;
    logic            ff_empty;
    logic            ff_full;
    logic            stage_done;
    logic [2:0]      err_flags;

    twdl_idx_gen_cta #(
        .wTwIdx(W), .wAddr(AW), .FF_DEPTH(D), .wBlk(WB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_factor(cfg_factor), .cfg_demontr(cfg_demontr),
        .cfg_ngrp(cfg_ngrp), .cfg_nblk(cfg_nblk),
        .in_val(in_val), .out_val(out_val), .factor(factor),
        .twdl_numrtr(twdl_numrtr), .twdl_demontr(twdl_demontr),
        .rdreq_ff_addr(rdreq_ff_addr), .sclr_ff_addr(sclr_ff_addr),
        .rdaddr(rdaddr), .ff_empty(ff_empty), .ff_full(ff_full),
        .stage_done(stage_done), .err_flags(err_flags)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int       m_ph = 0;
    int       m_r = 0, m_n = 0, m_m = 0, m_nblk = 0;
    int       m_k = 0, m_blk = 0, m_beat = 0;
    logic [2:0] m_err = '0;
    int       m_ff[$];
    int       m_rd = 0;
    num_t     sb[$];
    num_t     mon_e;
    vec_t     tv[4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic num_t exp_num(input int r, input int k);
        num_t t;
        for (int n = 0; n < 5; n++) t[n] = (n < r) ? W'(n * k) : '0;
        return t;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_val) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL out_val: got unexpected beat %0h expected none", twdl_numrtr);
            end else begin
                mon_e = sb.pop_front();
                chk("numrtr", 64'(twdl_numrtr), 64'(mon_e));
            end
        end
    end

    task automatic set_cfg(input int r, input int n, input int m, input int nb);
        cfg_factor  = 3'(r);
        cfg_demontr = W'(n);
        cfg_ngrp    = W'(m);
        cfg_nblk    = WB'(nb);
    endtask

    // one clock cycle of stimulus with model update and per-cycle checks
    task automatic cyc(input bit v, input bit p, input bit s, input bit st);
        bit exp_sd;
        bit push;
        int ph0;
        in_val = v; rdreq_ff_addr = p; sclr_ff_addr = s; start = st;
        ph0    = m_ph;
        exp_sd = (ph0 == 2);
        push   = v && (ph0 == 1) && !st;
        if (s) begin
            m_ff.delete();
        end else begin
            if (p && m_ff.size() == 0) m_err[1] = 1'b1;
            if (p && m_ff.size() > 0) m_rd = m_ff.pop_front();
            if (push) begin
                if (m_ff.size() < D) m_ff.push_back(m_beat % 4096);
                else m_err[2] = 1'b1;
            end
        end
        if (st) begin
            m_ph = 1; m_r = int'(cfg_factor); m_n = int'(cfg_demontr);
            m_m = int'(cfg_ngrp); m_nblk = int'(cfg_nblk);
            m_k = 0; m_blk = 0; m_beat = 0; m_err = '0;
        end else begin
            case (ph0)
                0: if (v) m_err[0] = 1'b1;
                1: if (v) begin
                    sb.push_back(exp_num(m_r, m_k));
                    m_beat++;
                    if (m_k == m_m - 1) begin
                        m_k = 0;
                        if (m_blk == m_nblk - 1) m_ph = 2;
                        m_blk++;
                    end else begin
                        m_k++;
                    end
                end
                default: m_ph = 0;
            endcase
        end
        @(posedge clk);
        #1;
        in_val = 1'b0; rdreq_ff_addr = 1'b0; sclr_ff_addr = 1'b0; start = 1'b0;
        chk("stage_done", 64'(stage_done), 64'(exp_sd));
        chk("err_flags", 64'(err_flags), 64'(m_err));
        chk("ff_empty", 64'(ff_empty), 64'(m_ff.size() == 0));
        chk("ff_full", 64'(ff_full), 64'(m_ff.size() == D));
        chk("rdaddr", 64'(rdaddr), 64'(m_rd));
        chk("factor", 64'(factor), 64'(m_r));
        chk("twdl_demontr", 64'(twdl_demontr), 64'(m_n));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_val"}, 64'(out_val), 64'(0));
        chk({tag, "_numrtr"}, 64'(twdl_numrtr), 64'(0));
        chk({tag, "_factor"}, 64'(factor), 64'(0));
        chk({tag, "_demontr"}, 64'(twdl_demontr), 64'(0));
        chk({tag, "_rdaddr"}, 64'(rdaddr), 64'(0));
        chk({tag, "_ff_empty"}, 64'(ff_empty), 64'(1));
        chk({tag, "_ff_full"}, 64'(ff_full), 64'(0));
        chk({tag, "_stage_done"}, 64'(stage_done), 64'(0));
        chk({tag, "_err_flags"}, 64'(err_flags), 64'(0));
    endtask

    task automatic model_reset();
        m_ph = 0; m_r = 0; m_n = 0; m_m = 0; m_nblk = 0;
        m_k = 0; m_blk = 0; m_beat = 0; m_err = '0; m_rd = 0;
        m_ff.delete();
        sb.delete();
    endtask

    initial begin
        tv[0] = '{4, 16, 4, 1, 0, {12'd0, 12'd3, 12'd6, 12'd9,  12'd0}};
        tv[1] = '{5, 25, 5, 2, 1, {12'd0, 12'd4, 12'd8, 12'd12, 12'd16}};
        tv[2] = '{2,  8, 4, 1, 0, {12'd0, 12'd3, 12'd0, 12'd0,  12'd0}};
        tv[3] = '{3, 12, 4, 2, 2, {12'd0, 12'd3, 12'd6, 12'd0,  12'd0}};

        #12;
        chk_reset_outputs("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // stage table: back-to-back and gapped beats, then drain the addresses
        for (int i = 0; i < 4; i++) begin
            set_cfg(tv[i].r, tv[i].n, tv[i].m, tv[i].nblk);
            cyc(0, 0, 0, 1);
            for (int b = 0; b < tv[i].m * tv[i].nblk; b++) begin
                cyc(1, 0, 0, 0);
                for (int g = 0; g < tv[i].gap; g++) cyc(0, 0, 0, 0);
            end
            repeat (3) cyc(0, 0, 0, 0);
            chk("numrtr_hold", 64'(twdl_numrtr), 64'(tv[i].last));
            chk("fifo_level", 64'(m_ff.size()), 64'(tv[i].m * tv[i].nblk));
            while (m_ff.size() > 0) cyc(0, 1, 0, 0);
            chk("sb_drained", 64'(sb.size()), 64'(0));
        end

        // FIFO overflow, full drain, underflow, push+pop at full, start and sclr
        set_cfg(2, 256, 128, 1);
        cyc(0, 0, 0, 1);
        repeat (33) cyc(1, 0, 0, 0);
        chk("ovf_flag", 64'(err_flags[2]), 64'(1));
        repeat (32) cyc(0, 1, 0, 0);
        chk("drain_last", 64'(rdaddr), 64'(31));
        cyc(0, 1, 0, 0);
        chk("udf_flag", 64'(err_flags[1]), 64'(1));
        repeat (32) cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        chk("full_after_pushpop", 64'(ff_full), 64'(1));
        cyc(0, 0, 0, 1);
        cyc(1, 0, 1, 0);
        chk("sclr_empty", 64'(ff_empty), 64'(1));
        cyc(0, 0, 0, 0);

        // asynchronous reset between edges in the middle of a stage
        cyc(1, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // in_val while idle, then start clears flags, then an r=2 stage
        cyc(1, 0, 0, 0);
        chk("idle_no_out_val", 64'(out_val), 64'(0));
        set_cfg(2, 8, 4, 1);
        cyc(0, 0, 0, 1);
        repeat (4) cyc(1, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0);
        while (m_ff.size() > 0) cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk("sb_final", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
